load_store_unit: RTL

// - Data-side load/store unit between execute stage and a single-port 32-bit data memory.
// - Accepts one LOAD/STORE per handshake and decodes funct3 as BYTE/HALF/WORD/BYTE_U/HALF_U.
// - Stores: byte lanes replicated, byte enables generated. Loads: lane extracted, sign/zero extended.
// - Intercepts a parametrised bank of memory-mapped output ports; these never reach memory.

---
 rtl/load_store_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-side load/store unit: funct3 decode, byte-lane steering, memory handshake, MMIO outports.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned HALF/WORD accesses bypass and flag misalign_err.
module load_store_unit #(
  parameter int unsigned NUM_OUTPORTS = 1,
  parameter logic [31:0] OUTPORT_BASE = 32'h0000_FFFC,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_be,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  output logic [32*NUM_OUTPORTS-1:0] outport
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                      misalign_err
`endif
);

  typedef enum logic [2:0] {
    F_BYTE   = 3'b000,
    F_HALF   = 3'b001,
    F_WORD   = 3'b010,
    F_BYTE_U = 3'b100,
    F_HALF_U = 3'b101
  } funct3_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_MMIO,
    S_BYPASS,
    S_RESP
  } state_t;

  state_t              state_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic [3:0]          mem_be_q;
  logic [31:0]         port_q [NUM_OUTPORTS];

  logic [1:0]          size_d;
  logic [1:0]          eff_off_d;
  logic                bypass_d;
  logic [31:0]         wdata_d;
  logic [3:0]          be_d;
  logic [NUM_OUTPORTS-1:0] hit_d;
  logic [31:0]         port_rd_d;
  logic [31:0]         merged_d;
  logic [ADDR_W-3:0]   pw_d;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F_BYTE:   return {{24{b[7]}}, b};
      F_HALF:   return {{16{h[15]}}, h};
      F_WORD:   return w;
      F_BYTE_U: return {24'h0, b};
      F_HALF_U: return {16'h0, h};
      default:  return '0;
    endcase
  endfunction

  assign size_d = req_funct3[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misal_d;
  logic misalign_q;
  assign misal_d   = ((size_d == 2'b01) && req_addr[0]) || ((size_d == 2'b10) && (req_addr[1:0] != 2'b00));
  assign eff_off_d = req_addr[1:0];
  assign bypass_d  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || misal_d;
  assign misalign_err = misalign_q;
`else
  // Misaligned offsets are silently rounded down to the access size.
  always_comb begin
    eff_off_d = req_addr[1:0];
    if (size_d == 2'b01)      eff_off_d = {req_addr[1], 1'b0};
    else if (size_d == 2'b10) eff_off_d = 2'b00;
  end
  assign bypass_d = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`endif

  always_comb begin
    wdata_d = req_wdata;
    be_d    = 4'b1111;
    case (size_d)
      2'b00: begin
        wdata_d = {4{req_wdata[7:0]}};
        be_d    = 4'b0001 << eff_off_d;
      end
      2'b01: begin
        wdata_d = {2{req_wdata[15:0]}};
        be_d    = eff_off_d[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_d     = '0;
    port_rd_d = '0;
    pw_d      = '0;
    for (int unsigned i = 0; i < NUM_OUTPORTS; i++) begin
      pw_d = (ADDR_W-2)'((OUTPORT_BASE + 32'(4 * i)) >> 2);
      if (req_addr[ADDR_W-1:2] == pw_d) begin
        hit_d[i]  = 1'b1;
        port_rd_d = port_q[i];
      end
    end
    for (int unsigned b = 0; b < 4; b++)
      merged_d[8*b +: 8] = be_d[b] ? wdata_d[8*b +: 8] : port_rd_d[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      for (int unsigned i = 0; i < NUM_OUTPORTS; i++) port_q[i] <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= eff_off_d;
            if (bypass_d) begin
              state_q      <= S_BYPASS;
              resp_valid_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
              misalign_q   <= misal_d;
`endif
            end else if (|hit_d) begin
              state_q      <= S_MMIO;
              resp_valid_q <= 1'b1;
              if (req_we) begin
                for (int unsigned i = 0; i < NUM_OUTPORTS; i++)
                  if (hit_d[i]) port_q[i] <= merged_d;
              end else begin
                resp_rdata_q <= load_extract(port_rd_d, req_funct3, eff_off_d);
              end
            end else begin
              state_q     <= S_MEM_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= wdata_d;
              mem_be_q    <= req_we ? be_d : 4'b1111;
            end
          end
        end
        S_MEM_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (we_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_rvalid) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_extract(mem_rdata, f3_q, off_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

  for (genvar g = 0; g < NUM_OUTPORTS; g++) begin : g_out
    assign outport[32*g +: 32] = port_q[g];
  end

endmodule
